// File: rtl/mem_access_unit.sv
// Data-memory access unit: accepts one load/store request at a time over a
// valid/ready handshake, waits WAIT_STATES extra cycles, performs the access
// on a little-endian byte RAM, and holds a response until it is consumed.
//
// Handshake rules (both channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The request channel is ready only in IDLE. The response channel is valid
//   only in RESP. Response outputs hold steady until the transfer completes.
//   Requests are never accepted in the same cycle a response is consumed.
//   req_ready goes high in the cycle after the response transfer.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;
  localparam logic [1:0] CAUSE_FUNCT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]  wait_cnt;
  logic        lat_store;
  logic [2:0]  lat_funct;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [7:0]  mem [DEPTH];

  logic        accept;
  logic        access;
  logic        resp_done;

  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic        bad_funct;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [1:0]  cause;

  logic [ADDR_WIDTH-1:0] idx0;
  logic [ADDR_WIDTH-1:0] idx1;
  logic [ADDR_WIDTH-1:0] idx2;
  logic [ADDR_WIDTH-1:0] idx3;
  logic [31:0] load_data;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign dbg_state  = state;

  assign accept    = req_valid & req_ready;
  assign resp_done = resp_valid & resp_ready;
  // The access happens on the edge that leaves WAIT with the counter at zero.
  assign access    = (state == S_WAIT) && (wait_cnt == 4'd0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept)    state_next = S_WAIT;
      S_WAIT: if (access)    state_next = S_RESP;
      S_RESP: if (resp_done) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Capture the request on acceptance; later req_* changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_store <= 1'b0;
      lat_funct <= 3'b000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (accept) begin
      lat_store <= req_store;
      lat_funct <= req_funct;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Wait-state counter: loaded on accept, counts down while in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_STATES);
    end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Any upper address bit set means the address lies past the RAM.
  generate
    if (ADDR_WIDTH < 32) begin : g_range
      assign out_of_range = |lat_addr[31:ADDR_WIDTH];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Fault decode on the latched request; invalid funct outranks alignment,
  // which outranks range.
  always_comb begin
    size_byte  = (lat_funct[1:0] == 2'b00);
    size_half  = (lat_funct[1:0] == 2'b01);
    size_word  = (lat_funct[1:0] == 2'b10);
    if (lat_store) begin
      bad_funct = (lat_funct == 3'b011) || lat_funct[2];
    end else begin
      bad_funct = (lat_funct == 3'b011) || (lat_funct[2:1] == 2'b11);
    end
    misaligned = (size_half && lat_addr[0]) ||
                 (size_word && (lat_addr[1:0] != 2'b00));
    fault = 1'b1;
    cause = CAUSE_NONE;
    if (bad_funct) begin
      cause = CAUSE_FUNCT;
    end else if (misaligned) begin
      cause = CAUSE_ALIGN;
    end else if (out_of_range) begin
      cause = CAUSE_RANGE;
    end else begin
      fault = 1'b0;
    end
  end

  // Byte lanes of the access; indices wrap inside the RAM so they never
  // leave the array, and any real wrap is already flagged as a fault.
  assign idx0 = lat_addr[ADDR_WIDTH-1:0];
  assign idx1 = idx0 + ADDR_WIDTH'(1);
  assign idx2 = idx0 + ADDR_WIDTH'(2);
  assign idx3 = idx0 + ADDR_WIDTH'(3);

  // Little-endian load formatting with sign or zero extension.
  always_comb begin
    load_data = 32'h0;
    case (lat_funct)
      3'b000:  load_data = {{24{mem[idx0][7]}}, mem[idx0]};
      3'b001:  load_data = {{16{mem[idx1][7]}}, mem[idx1], mem[idx0]};
      3'b010:  load_data = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
      3'b100:  load_data = {24'h0, mem[idx0]};
      3'b101:  load_data = {16'h0, mem[idx1], mem[idx0]};
      default: load_data = 32'h0;
    endcase
  end

  // Response registers, updated only at the access edge and held in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      resp_cause <= CAUSE_NONE;
    end else if (access) begin
      resp_fault <= fault;
      resp_cause <= cause;
      resp_rdata <= (lat_store || fault) ? 32'h0 : load_data;
    end
  end

  // RAM write port: only the addressed bytes of a non-faulting store.
  // Not reset; during reset the FSM sits in IDLE so no write can happen.
  always_ff @(posedge clk) begin
    if (access && lat_store && !fault) begin
      mem[idx0] <= lat_wdata[7:0];
      if (!size_byte) begin
        mem[idx1] <= lat_wdata[15:8];
      end
      if (size_word) begin
        mem[idx2] <= lat_wdata[23:16];
        mem[idx3] <= lat_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: unit 0 has no wait states, unit 1 has three. Each step
// issues one request, checks latency, optional back-pressure stability,
// response contents and the return to IDLE.
module tb_mem_access_unit;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_store  [2];
  logic [2:0]  req_funct  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_fault [2];
  logic [1:0]  resp_cause [2];
  logic [1:0]  dbg_state  [2];

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_funct(req_funct[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
    .resp_cause(resp_cause[0]), .dbg_state(dbg_state[0])
  );

  mem_access_unit #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_funct(req_funct[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
    .resp_cause(resp_cause[1]), .dbg_state(dbg_state[1])
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "/req_ready"},  32'(req_ready[u]),  32'd1);
    check({tag, "/resp_valid"}, 32'(resp_valid[u]), 32'd0);
  endtask

  // One full transaction with latency, stability and response checks.
  task automatic txn(input int u, input logic st, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wd, input int ws,
                     input logic [31:0] exp_rd, input logic exp_flt,
                     input logic [1:0] exp_cause, input int hold, input string tag);
    int n;
    @(negedge clk);
    check({tag, "/ready_in"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_store[u] = st;
    req_funct[u] = f;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    @(posedge clk);
    #1;
    // Garbage on the request bus while busy must be ignored.
    req_store[u] = ~st;
    req_funct[u] = 3'($urandom_range(0, 7));
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    n = 0;
    while (resp_valid[u] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(ws + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(resp_valid[u]), 32'd1);
      check({tag, "/hold_ready"}, 32'(req_ready[u]), 32'd0);
      check({tag, "/hold_rdata"}, resp_rdata[u], exp_rd);
    end
    @(negedge clk);
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    check({tag, "/rdata"}, resp_rdata[u], exp_rd);
    check({tag, "/fault"}, 32'(resp_fault[u]), 32'(exp_flt));
    check({tag, "/cause"}, 32'(resp_cause[u]), 32'(exp_cause));
    @(posedge clk);
    #1;
    resp_ready[u] = 1'b0;
    check_idle(u, {tag, "/after"});
  endtask

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_store[u] = 1'b0;
      req_funct[u] = 3'b000; req_addr[u] = 32'h0; req_wdata[u] = 32'h0;
      resp_ready[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_idle(u, "reset");
      check("reset/rdata", resp_rdata[u], 32'h0);
      check("reset/fault", 32'(resp_fault[u]), 32'd0);
      check("reset/cause", 32'(resp_cause[u]), 32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Unit 0: basic store/load and extension.
    txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 2'b00, 0, "sw10");
    txn(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 2'b00, 0, "lw10");
    txn(0, 0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0, 2'b00, 0, "lb13");
    txn(0, 0, 3'b100, 32'h13, 32'h0, 0, 32'h000000DE, 0, 2'b00, 0, "lbu13");
    txn(0, 0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 0, 2'b00, 0, "lh12");
    txn(0, 0, 3'b101, 32'h10, 32'h0, 0, 32'h0000BEEF, 0, 2'b00, 0, "lhu10");
    txn(0, 0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 0, 2'b00, 0, "lb10");
    txn(0, 0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFFBEEF, 0, 2'b00, 0, "lh10");

    // Partial stores.
    txn(0, 1, 3'b001, 32'h12, 32'hFFFF1234, 0, 32'h0, 0, 2'b00, 0, "sh12");
    txn(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'h1234BEEF, 0, 2'b00, 0, "lw_sh");
    txn(0, 1, 3'b000, 32'h11, 32'h777777AA, 0, 32'h0, 0, 2'b00, 0, "sb11");
    txn(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'h1234AAEF, 0, 2'b00, 0, "lw_sb");

    // Faults and their priority.
    txn(0, 1, 3'b010, 32'h00, 32'h01020304, 0, 32'h0, 0, 2'b00, 0, "sw00");
    txn(0, 0, 3'b010, 32'h02, 32'h0, 0, 32'h0, 1, 2'b01, 0, "lw02_mis");
    txn(0, 0, 3'b001, 32'h13, 32'h0, 0, 32'h0, 1, 2'b01, 0, "lh13_mis");
    txn(0, 1, 3'b010, 32'h100, 32'hCAFEF00D, 0, 32'h0, 1, 2'b10, 0, "sw100_oor");
    txn(0, 1, 3'b010, 32'h110, 32'hCAFEF00D, 0, 32'h0, 1, 2'b10, 0, "sw110_oor");
    txn(0, 0, 3'b010, 32'h00, 32'h0, 0, 32'h01020304, 0, 2'b00, 0, "lw00_kept");
    txn(0, 0, 3'b010, 32'h10, 32'h0, 0, 32'h1234AAEF, 0, 2'b00, 0, "lw10_kept");
    txn(0, 1, 3'b100, 32'h101, 32'h0, 0, 32'h0, 1, 2'b11, 0, "s100_bad");
    txn(0, 0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1, 2'b11, 0, "l011_bad");
    txn(0, 0, 3'b110, 32'h100, 32'h0, 0, 32'h0, 1, 2'b11, 0, "l110_bad");
    txn(0, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1, 2'b01, 0, "lw102_mis");
    txn(0, 0, 3'b000, 32'h80000000, 32'h0, 0, 32'h0, 1, 2'b10, 0, "lb_hi_oor");

    // Unit 1: wait states and back-pressure.
    txn(1, 1, 3'b010, 32'h20, 32'h11223344, 3, 32'h0, 0, 2'b00, 5, "w3_sw20");
    txn(1, 0, 3'b010, 32'h20, 32'h0, 3, 32'h11223344, 0, 2'b00, 5, "w3_lw20");

    // Reset while in WAIT abandons the store.
    @(negedge clk);
    req_valid[1] = 1'b1; req_store[1] = 1'b1; req_funct[1] = 3'b010;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h99999999;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check_idle(1, "rst_wait");
    check("rst_wait/rdata", resp_rdata[1], 32'h0);
    @(negedge clk);
    rst[1] = 1'b0;
    txn(1, 0, 3'b010, 32'h20, 32'h0, 3, 32'h11223344, 0, 2'b00, 0, "w3_lw20_after");

    // Reset in RESP: the store already happened and persists.
    @(negedge clk);
    req_valid[1] = 1'b1; req_store[1] = 1'b1; req_funct[1] = 3'b010;
    req_addr[1] = 32'h24; req_wdata[1] = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    n = 0;
    while (resp_valid[1] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_resp/latency", 32'(n), 32'd4);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check_idle(1, "rst_resp");
    @(negedge clk);
    rst[1] = 1'b0;
    txn(1, 0, 3'b010, 32'h24, 32'h0, 3, 32'h5A5A5A5A, 0, 2'b00, 0, "w3_lw24");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised data-memory access unit, successor to the single-cycle byte-array memory stage.
Adds a valid/ready request and response handshake, configurable memory depth and wait-state latency, signed and unsigned loads, out-of-range detection and a fault-cause code.
Sits between the core's execute stage and a local byte-addressed data RAM, little-endian.

Parameters:
ADDR_WIDTH, 8, byte-address bits implemented; memory depth = 2**ADDR_WIDTH bytes (min 2)
WAIT_STATES, 0, extra cycles inserted before each access (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_store  input  1  1 = store, 0 = load
req_funct  input  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
req_addr  input  32  byte address
req_wdata  input  32  store data, low bytes used
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  load result (0 for stores and faults)
resp_fault  output  1  request faulted
resp_cause  output  2  00 none, 01 misaligned, 10 out of range, 11 invalid funct

Behaviour:
- Reset (async): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, resp_cause=00, wait counter=0. RAM contents not reset.
- FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: req_ready=1. Accept on req_valid&req_ready. Latch store, funct, addr, wdata. Go to WAIT with counter=WAIT_STATES.
  - WAIT: req_ready=0. If counter!=0, decrement. If counter==0, perform access (write or read + decode) at this edge and go to RESP.
  - RESP: resp_valid=1, outputs stable until resp_ready. On resp_valid&resp_ready go to IDLE. No request accepted in the same cycle; req_ready rises the cycle after the handshake.
- Latency: accept at edge N, resp_valid high after edge N+1+WAIT_STATES. Throughput is one request per WAIT_STATES+3 cycles with resp_ready held high.
- Fault decode, on latched request, priority high to low:
  - invalid funct -> 11. Load funct 011/11x; store funct 011 or 1xx.
  - misaligned -> 01. Half with addr[0]=1; word with addr[1:0]!=0.
  - out of range -> 10. req_addr[31:ADDR_WIDTH]!=0.
- Faulted request: no RAM write, resp_rdata=0, resp_fault=1. Still passes through WAIT/RESP with identical timing.
- Load data, little-endian: byte at addr in bits 7:0.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW takes 4 bytes at addr..addr+3.
- Store writes only the addressed 1/2/4 bytes; other bytes unchanged. resp_rdata=0 on stores.
- Reset mid-operation: request in WAIT is abandoned with no write. A write already performed at the WAIT->RESP edge persists; its response is dropped.
- req_* inputs ignored outside IDLE; changes after acceptance have no effect.
- resp_ready outside RESP ignored.

Test Plan:
- WAIT_STATES=0: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, fault 0. resp_valid exactly 1 edge after accept.
- After that store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SH 0x12 data 0x1234 over 0xDEADBEEF, then LW 0x10 -> 0x1234BEEF. SB 0x11 data 0xAA -> LW 0x10 = 0x1234AAEF.
- Faults: LW 0x02 -> cause 01, rdata 0. SW 0x100 (ADDR_WIDTH=8) -> cause 10, memory unchanged. Store funct 100 at 0x101 -> cause 11.
- WAIT_STATES=3: accept at edge N -> resp_valid after edge N+4. Hold resp_ready=0 for 5 cycles -> outputs stable and req_ready=0; release -> IDLE next cycle.
- Assert reset during WAIT of SW 0x20 with WAIT_STATES=3 -> resp_valid=0 immediately, req_ready=1. Subsequent LW 0x20 returns the prior contents.
